// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state codes, digit limits and
// the preset clamp helper.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

    // Out-of-range preset digits saturate to the digit's maximum.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d, input logic [3:0] max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; wraps 0 -> MAX on a decrement and reports a borrow when zero.
module bcd_digit_down
    import bcd_timer_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_UNITS
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic       borrow_out
);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            value <= 4'd0;
        end else if (clear) begin
            value <= 4'd0;
        end else if (load) begin
            value <= clamp_bcd(load_val, MAX);
        end else if (en && borrow_in) begin
            value <= (value == 4'd0) ? MAX : value - 4'd1;
        end
    end

    // Borrow propagates independently of en, so the chain doubles as the zero detector.
    assign borrow_out = borrow_in && (value == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD mm:ss countdown timer with prescaler, load/start/pause/clear controls and
// done flags; the digits form a ripple borrow chain from seconds units upward.
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned MIN_DIGITS = 2,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*MIN_DIGITS-1:0] load_min,
    input  logic [3:0]              load_sec_tens,
    input  logic [3:0]              load_sec_units,
    input  logic                    start,
    input  logic                    pause,
    output logic [3:0]              seconds_units,
    output logic [3:0]              seconds_tens,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic                    running,
    output logic                    done,
    output logic                    done_pulse
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam int unsigned N_DIG = MIN_DIGITS + 2;

    state_t           state, state_d;
    logic [PRE_W-1:0] prescaler, prescaler_d;
    logic             done_pulse_d;

    logic             tick;
    logic             zero;
    logic             is_one;
    logic             dec;
    logic             load_ok;
    logic [N_DIG:0]   borrow;
    wire  [3:0]       min_dig [MIN_DIGITS];

    assign tick    = (prescaler == PRE_LAST);
    assign load_ok = load && !clear && (state != ST_RUN);
    assign dec     = (state == ST_RUN) && !clear && !pause && tick && !zero;

    // Borrow chain seeded with 1: the final borrow_out is high only when every digit is 0.
    assign borrow[0] = 1'b1;
    assign zero      = borrow[N_DIG];
    assign is_one    = (seconds_units == 4'd1) && (seconds_tens == 4'd0) &&
                       (minutes == '0);

    bcd_digit_down #(
        .MAX(BCD_MAX_UNITS)
    ) u_sec_units (
        .CLK       (CLK),
        .Reset     (Reset),
        .clear     (clear),
        .load      (load_ok),
        .load_val  (load_sec_units),
        .en        (dec),
        .borrow_in (borrow[0]),
        .value     (seconds_units),
        .borrow_out(borrow[1])
    );

    bcd_digit_down #(
        .MAX(BCD_MAX_TENS)
    ) u_sec_tens (
        .CLK       (CLK),
        .Reset     (Reset),
        .clear     (clear),
        .load      (load_ok),
        .load_val  (load_sec_tens),
        .en        (dec),
        .borrow_in (borrow[1]),
        .value     (seconds_tens),
        .borrow_out(borrow[2])
    );

    for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
        bcd_digit_down #(
            .MAX(BCD_MAX_UNITS)
        ) u_min (
            .CLK       (CLK),
            .Reset     (Reset),
            .clear     (clear),
            .load      (load_ok),
            .load_val  (load_min[4*i +: 4]),
            .en        (dec),
            .borrow_in (borrow[i+2]),
            .value     (min_dig[i]),
            .borrow_out(borrow[i+3])
        );
    end

    always_comb begin
        minutes = '0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            minutes[4*i +: 4] = min_dig[i];
        end
    end

    always_comb begin
        state_d      = state;
        prescaler_d  = prescaler;
        done_pulse_d = 1'b0;
        if (clear) begin
            state_d     = ST_IDLE;
            prescaler_d = '0;
        end else if (load_ok) begin
            state_d     = ST_IDLE;
            prescaler_d = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    // Pause wins over a coincident tick: digits and prescaler hold.
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        prescaler_d = tick ? '0 : prescaler + PRE_W'(1);
                        if (tick && is_one) begin
                            state_d      = ST_DONE;
                            done_pulse_d = 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_PAUSED: begin
                    if (!pause && start && !zero) begin
                        state_d     = ST_RUN;
                        prescaler_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            prescaler  <= '0;
            done_pulse <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            prescaler  <= prescaler_d;
            done_pulse <= done_pulse_d;
            running    <= (state_d == ST_RUN);
            done       <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: one instance with TICK_DIV=1, one with TICK_DIV=4,
// both fed the same controls.
module tb_bcd_countdown_timer;

    logic       CLK;
    logic       Reset;
    logic       clear;
    logic       load;
    logic [7:0] load_min;
    logic [3:0] load_sec_tens;
    logic [3:0] load_sec_units;
    logic       start;
    logic       pause;

    logic [3:0] u1, t1, u4, t4;
    logic [7:0] m1, m4;
    logic       r1, d1, p1, r4, d4, p4;
    logic [15:0] cnt1, cnt4;

    int total = 0;
    int bad   = 0;

    assign cnt1 = {m1, t1, u1};
    assign cnt4 = {m4, t4, u4};

    bcd_countdown_timer #(
        .MIN_DIGITS(2),
        .TICK_DIV  (1)
    ) dut1 (
        .CLK           (CLK),
        .Reset         (Reset),
        .clear         (clear),
        .load          (load),
        .load_min      (load_min),
        .load_sec_tens (load_sec_tens),
        .load_sec_units(load_sec_units),
        .start         (start),
        .pause         (pause),
        .seconds_units (u1),
        .seconds_tens  (t1),
        .minutes       (m1),
        .running       (r1),
        .done          (d1),
        .done_pulse    (p1)
    );

    bcd_countdown_timer #(
        .MIN_DIGITS(2),
        .TICK_DIV  (4)
    ) dut4 (
        .CLK           (CLK),
        .Reset         (Reset),
        .clear         (clear),
        .load          (load),
        .load_min      (load_min),
        .load_sec_tens (load_sec_tens),
        .load_sec_units(load_sec_units),
        .start         (start),
        .pause         (pause),
        .seconds_units (u4),
        .seconds_tens  (t4),
        .minutes       (m4),
        .running       (r4),
        .done          (d4),
        .done_pulse    (p4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [7:0] mn, input logic [3:0] tn, input logic [3:0] un);
        load           = 1'b1;
        load_min       = mn;
        load_sec_tens  = tn;
        load_sec_units = un;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    initial begin
        Reset          = 1'b1;
        clear          = 1'b0;
        load           = 1'b0;
        load_min       = 8'h00;
        load_sec_tens  = 4'h0;
        load_sec_units = 4'h0;
        start          = 1'b0;
        pause          = 1'b0;
        #12;
        check("rst_cnt", cnt1, 16'h0000);
        check("rst_run", r1, 1'b0);
        check("rst_done", d1, 1'b0);
        check("rst_pulse", p1, 1'b0);
        Reset = 1'b0;

        // Full countdown 01:05 at one tick per edge
        do_load(8'h01, 4'h0, 4'h5);
        check("t1_load", cnt1, 16'h0105);
        check("t1_idle", r1, 1'b0);
        do_start();
        check("t1_run", r1, 1'b1);
        check("t1_start_edge", cnt1, 16'h0105);
        step();
        check("t1_first_dec", cnt1, 16'h0104);
        steps(5);
        check("t1_min_borrow", cnt1, 16'h0059);
        steps(58);
        check("t1_at_one", cnt1, 16'h0001);
        check("t1_no_pulse_yet", p1, 1'b0);
        step();
        check("t1_zero", cnt1, 16'h0000);
        check("t1_done", d1, 1'b1);
        check("t1_pulse", p1, 1'b1);
        check("t1_run_off", r1, 1'b0);
        step();
        check("t1_pulse_once", p1, 1'b0);
        check("t1_done_hold", d1, 1'b1);
        check("t1_no_wrap", cnt1, 16'h0000);

        // start in DONE, clear, start on 00:00
        do_start();
        check("t5_start_done", d1, 1'b1);
        check("t5_start_done_run", r1, 1'b0);
        do_clear();
        check("t5_clear_done", d1, 1'b0);
        do_start();
        check("t5_start_zero", r1, 1'b0);
        check("t5_start_zero_cnt", cnt1, 16'h0000);

        // Prescaled countdown with pause/resume
        do_clear();
        do_load(8'h00, 4'h0, 4'h3);
        do_start();
        check("t2_run", r4, 1'b1);
        steps(3);
        check("t2_before_tick", cnt4, 16'h0003);
        step();
        check("t2_tick", cnt4, 16'h0002);
        do_pause();
        check("t2_paused_run", r4, 1'b0);
        check("t2_paused_cnt", cnt4, 16'h0002);
        steps(20);
        check("t2_hold", cnt4, 16'h0002);
        check("t2_hold_run", r4, 1'b0);
        do_start();
        check("t2_resume", r4, 1'b1);
        steps(3);
        check("t2_resume_wait", cnt4, 16'h0002);
        step();
        check("t2_resume_tick", cnt4, 16'h0001);

        // Pause on a tick edge suppresses the decrement
        do_clear();
        do_load(8'h00, 4'h0, 4'h5);
        do_start();
        do_pause();
        check("tp_pause_tick", cnt1, 16'h0005);
        check("tp_paused", r1, 1'b0);
        do_start();
        step();
        check("tp_resume", cnt1, 16'h0004);

        // Ripple borrow across minute digits, load ignored in RUN
        do_clear();
        do_load(8'h99, 4'h5, 4'h9);
        do_start();
        steps(59);
        check("t3_9900", cnt1, 16'h9900);
        step();
        check("t3_9859", cnt1, 16'h9859);
        do_load(8'h01, 4'h0, 4'h0);
        check("t3_load_in_run", cnt1, 16'h9858);
        check("t3_load_in_run_r", r1, 1'b1);
        do_clear();
        do_load(8'h10, 4'h0, 4'h0);
        do_start();
        step();
        check("t3_1000", cnt1, 16'h0959);

        // Clamp invalid BCD presets
        do_clear();
        do_load(8'h0F, 4'h7, 4'hC);
        check("t4_clamp", cnt1, 16'h0959);
        check("t4_clamp4", cnt4, 16'h0959);

        // Asynchronous reset between edges while running
        do_clear();
        do_load(8'h00, 4'h0, 4'h3);
        do_start();
        step();
        check("t6_pre", cnt1, 16'h0002);
        #3;
        Reset = 1'b1;
        #1;
        check("t6_async_cnt", cnt1, 16'h0000);
        check("t6_async_run", r1, 1'b0);
        check("t6_async_done", d1, 1'b0);
        #1;
        Reset = 1'b0;
        steps(4);
        check("t6_no_pulse", p1, 1'b0);
        check("t6_idle", r1, 1'b0);
        check("t6_not_done", d1, 1'b0);
        check("t6_cnt", cnt1, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
